// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO.
//   fifo_depth()   : number of entries for a given address width
//   DEF_*          : defaults used by the UART TX/RX buffer instances
package sync_fifo_pkg;

  localparam int DEF_DATASIZE  = 8;
  localparam int DEF_ADDRSIZE  = 4;
  localparam int DEF_AFULL_TH  = 12;
  localparam int DEF_AEMPTY_TH = 2;

  localparam int DEPTH = 1 << DEF_ADDRSIZE;
  localparam int PTRW  = DEF_ADDRSIZE + 1;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: one clocked write port, one asynchronous
// read port. It has no reset, so contents survive reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDRSIZE-1:0] i_waddr,
  input  logic [DATASIZE-1:0] i_wdata,
  input  logic [ADDRSIZE-1:0] i_raddr,
  output logic [DATASIZE-1:0] o_rdata
);

  localparam int MDEPTH = fifo_depth(ADDRSIZE);

  logic [DATASIZE-1:0] r_mem [MDEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with level counter, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a choice of
// registered or first-word-fall-through read data.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous flush (wins over winc/rinc)
//   winc, wdata          : write request and data
//   rinc, rdata          : read request/pop and data
//   wfull, rempty        : full / empty status
//   walmost_full         : level >= AFULL_TH
//   ralmost_empty        : level <= AEMPTY_TH
//   level                : stored word count, 0..DEPTH
//   overflow, underflow  : sticky error flags, cleared by clr or reset
module sync_fifo_ctl
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE  = DEF_DATASIZE,
  parameter int ADDRSIZE  = DEF_ADDRSIZE,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam int LDEPTH = fifo_depth(ADDRSIZE);
  localparam int LPTRW  = ADDRSIZE + 1;

  logic [LPTRW-1:0]    r_wptr, r_rptr, r_level;
  logic                r_overflow, r_underflow;
  logic                w_wr_acc, w_rd_acc, w_mem_we;
  logic [DATASIZE-1:0] w_mem_rdata;

  assign wfull  = (r_level == LPTRW'(LDEPTH));
  assign rempty = (r_level == '0);

  assign w_wr_acc = winc & ~wfull & ~clr;
  assign w_rd_acc = rinc & ~rempty & ~clr;
  // Gate with rst_n so a write in flight when reset falls never lands.
  assign w_mem_we = w_wr_acc & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (winc & wfull)  r_overflow  <= 1'b1;
      if (rinc & rempty) r_underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr[ADDRSIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ADDRSIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATASIZE-1:0] r_rdata;
      // Not cleared by clr: the last popped word stays visible.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rdata <= '0;
        else if (w_rd_acc) r_rdata <= w_mem_rdata;
      end
      assign rdata = r_rdata;
    end else begin : g_fwft_read
      // Head word is presented straight from the array; forced to zero
      // while empty so uninitialised storage never leaks out.
      assign rdata = rempty ? '0 : w_mem_rdata;
    end
  endgenerate

  assign level         = r_level;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign walmost_full  = (r_level >= LPTRW'(AFULL_TH));
  assign ralmost_empty = (r_level <= LPTRW'(AEMPTY_TH));

endmodule
